// File: rtl/ray_gen.sv
// ---------------------------------------------------------------------------
// ray_gen
//   Walks an H_RES x V_RES pixel grid in row-major order (x fastest) and
//   emits one primary ray per pixel into the origin/dir FIFOs of p_hit.
//   Each ray is the latched camera origin plus a per-pixel direction. The
//   direction is stepped incrementally, using adders only:
//     next column : dir     <= dir + du
//     next row    : row_acc <= row_acc + dv, dir <= row_acc + dv
//   All values are signed 32-bit fixed point with Q_BITS fractional bits.
//   Components are added independently and wrap silently on overflow.
//   Vectors pack as {x, y, z}: x is [95:64], y is [63:32], z is [31:0].
//
// Ports
//   i_clock      clock; all logic is on the rising edge
//   i_reset      synchronous, active-high reset; aborts any frame in flight
//   i_start      begins a frame; sampled only while idle
//   i_cam_origin camera origin, latched on an accepted start
//   i_dir_base   direction of pixel (0,0), latched on an accepted start
//   i_du         direction step per column, latched on an accepted start
//   i_dv         direction step per row, latched on an accepted start
//   i_out_full   downstream full (OR of the origin and dir FIFO fulls)
//   o_out_wr_en  write strobe to both downstream FIFOs
//   o_origin     ray origin presented with o_out_wr_en
//   o_dir        ray direction presented with o_out_wr_en
//   o_pixel_x    column of the ray currently presented
//   o_pixel_y    row of the ray currently presented
//   o_busy       high while rays are being emitted
//   o_done       one-cycle pulse after the last ray has been written
// ---------------------------------------------------------------------------
module ray_gen #(
  parameter int Q_BITS = 16,
  parameter int H_RES  = 64,
  parameter int V_RES  = 64
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [95:0] i_cam_origin,
  input  logic [95:0] i_dir_base,
  input  logic [95:0] i_du,
  input  logic [95:0] i_dv,
  input  logic        i_out_full,
  output logic        o_out_wr_en,
  output logic [95:0] o_origin,
  output logic [95:0] o_dir,
  output logic [15:0] o_pixel_x,
  output logic [15:0] o_pixel_y,
  output logic        o_busy,
  output logic        o_done
);

  // Q_BITS only labels the number format; values pass through unscaled.
  // An out-of-range setting leaves a marker block in the elaborated design.
  if (Q_BITS < 0 || Q_BITS > 31) begin : g_q_bits_out_of_range
  end

  localparam logic [15:0] X_LAST = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST = 16'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [95:0] r_origin;
  logic [95:0] r_dir;
  logic [95:0] r_row_acc;
  logic [95:0] r_du;
  logic [95:0] r_dv;
  logic [15:0] r_x;
  logic [15:0] r_y;

  logic        w_accept;
  logic        w_x_last;
  logic        w_y_last;
  logic [95:0] w_row_next;

  // Per-component 32-bit add; carries never cross into the next lane.
  function automatic logic [95:0] vec_add(input logic [95:0] a, input logic [95:0] b);
    logic [95:0] sum;
    sum[95:64] = a[95:64] + b[95:64];
    sum[63:32] = a[63:32] + b[63:32];
    sum[31:0]  = a[31:0]  + b[31:0];
    return sum;
  endfunction

  assign w_accept   = (r_state == S_RUN) && !i_out_full;
  assign w_x_last   = (r_x == X_LAST);
  assign w_y_last   = (r_y == Y_LAST);
  assign w_row_next = vec_add(r_row_acc, r_dv);

  // Next-state logic.
  // NOTE: assign a default before any branch so every path drives the
  // variable; otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (w_accept && w_x_last && w_y_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath. Every register here is plain flops, so all of them are
  // cleared by reset; an aborted frame leaves nothing to resume from.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_origin  <= '0;
      r_dir     <= '0;
      r_row_acc <= '0;
      r_du      <= '0;
      r_dv      <= '0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_origin  <= i_cam_origin;
            r_dir     <= i_dir_base;
            r_row_acc <= i_dir_base;
            r_du      <= i_du;
            r_dv      <= i_dv;
            r_x       <= '0;
            r_y       <= '0;
          end
        end
        S_RUN: begin
          // With i_out_full high nothing moves, so the presented ray stays
          // put until it is actually written.
          if (w_accept) begin
            if (!w_x_last) begin
              r_x   <= r_x + 16'd1;
              r_dir <= vec_add(r_dir, r_du);
            end else if (!w_y_last) begin
              r_x       <= '0;
              r_y       <= r_y + 16'd1;
              r_row_acc <= w_row_next;
              r_dir     <= w_row_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_wr_en = w_accept;
  assign o_origin    = r_origin;
  assign o_dir       = r_dir;
  assign o_pixel_x   = r_x;
  assign o_pixel_y   = r_y;
  assign o_busy      = (r_state == S_RUN);
  assign o_done      = (r_state == S_DONE);

endmodule
